// File: rtl/acc_writeback.sv
// Purpose : execute/writeback stage after the 8-bit accumulator ALU; holds acc/flags, runs data-memory load/store.
// Latency : single-cycle ops retire 1 cycle after accept; memory ops retire 1 cycle after mem_ready (2-cycle min occupancy).
// Backpres: ex_ready drops while a memory transaction is in flight; a transaction aborts after MEM_TIMEOUT wait cycles.
//
// Ports:
//   CLK, reset_n                  clock (rising edge), asynchronous active-low reset
//   ex_valid/ex_ready, op         upstream handshake and opcode (definitions package encoding)
//   alu_acc/alu_co/alu_z/alu_neg  ALU result and flags
//   mem_addr_in                   address operand for memory ops
//   acc_q/ci_q/z_q/neg_q          registered accumulator and flags (fed back to the ALU)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready   data-memory req/ready port
//   rf_we/rf_wdata                register-file write pulse for kLDR
//   retire                        one pulse per completed instruction
//   mem_err                       sticky transaction-timeout flag
// Optional: define ACC_WB_PERF_CNT_EN to add saturating perf_retired/perf_stall counters.

package definitions;
  localparam logic [3:0] kADD = 4'h0;
  localparam logic [3:0] kSUB = 4'h1;
  localparam logic [3:0] kSHL = 4'h2;
  localparam logic [3:0] kAND = 4'h3;
  localparam logic [3:0] kXOR = 4'h4;
  localparam logic [3:0] kSHR = 4'h5;
  localparam logic [3:0] kNOT = 4'h6;
  localparam logic [3:0] kLDI = 4'h7;
  localparam logic [3:0] kJMP = 4'h8;
  localparam logic [3:0] kBRZ = 4'h9;
  localparam logic [3:0] kBRN = 4'hA;
  localparam logic [3:0] kMLD = 4'hB;
  localparam logic [3:0] kLDR = 4'hC;
  localparam logic [3:0] kMST = 4'hD;
  localparam logic [3:0] kSTR = 4'hE;
  localparam logic [3:0] kCLR = 4'hF;
endpackage

module acc_writeback
  import definitions::*;
#(
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [3:0]    op,
  input  logic [DW-1:0] alu_acc,
  input  logic          alu_co,
  input  logic          alu_z,
  input  logic          alu_neg,
  input  logic [AW-1:0] mem_addr_in,
  output logic [DW-1:0] acc_q,
  output logic          ci_q,
  output logic          z_q,
  output logic          neg_q,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          rf_we,
  output logic [DW-1:0] rf_wdata,
  output logic          retire,
  output logic          mem_err
`ifdef ACC_WB_PERF_CNT_EN
  ,
  output logic [15:0]   perf_retired,
  output logic [15:0]   perf_stall
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_WR_WAIT} state_t;

  // Last wait-cycle count before abort; the counter only needs to reach this value.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [7:0]    tmo_cnt_q, tmo_cnt_d;
  logic          ldr_q, ldr_d;          // read in flight targets the register file
  logic [DW-1:0] acc_d;
  logic          ci_d, z_d, neg_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          rf_we_q, rf_we_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;
  logic          retire_q, retire_d;
  logic          mem_err_q, mem_err_d;

  // Handshake and request strobes decode straight from state so reset drops them at once.
  assign ex_ready  = (state_q == S_IDLE);
  assign mem_req   = (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);
  assign mem_we    = (state_q == S_WR_WAIT);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rf_we     = rf_we_q;
  assign rf_wdata  = rf_wdata_q;
  assign retire    = retire_q;
  assign mem_err   = mem_err_q;

  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    ldr_d       = ldr_q;
    acc_d       = acc_q;
    ci_d        = ci_q;
    z_d         = z_q;
    neg_d       = neg_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rf_we_d     = 1'b0;
    rf_wdata_d  = rf_wdata_q;
    retire_d    = 1'b0;
    mem_err_d   = mem_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          unique case (op)
            kADD, kSUB, kSHL: begin
              acc_d    = alu_acc;
              ci_d     = alu_co;
              z_d      = alu_z;
              neg_d    = alu_neg;
              retire_d = 1'b1;
            end
            kAND, kXOR, kSHR, kNOT, kLDI: begin
              acc_d    = alu_acc;
              z_d      = alu_z;
              neg_d    = alu_neg;
              retire_d = 1'b1;
            end
            kJMP, kBRZ: begin
              z_d      = alu_z;
              retire_d = 1'b1;
            end
            kBRN: begin
              retire_d = 1'b1;
            end
            kMLD, kLDR: begin
              state_d    = S_RD_WAIT;
              tmo_cnt_d  = 8'd0;
              ldr_d      = (op == kLDR);
              mem_addr_d = mem_addr_in;
            end
            kMST: begin
              state_d     = S_WR_WAIT;
              tmo_cnt_d   = 8'd0;
              mem_addr_d  = mem_addr_in;
              mem_wdata_d = acc_q;
            end
            kSTR: begin
              state_d     = S_WR_WAIT;
              tmo_cnt_d   = 8'd0;
              mem_addr_d  = mem_addr_in;
              mem_wdata_d = alu_acc;
              z_d         = alu_z;
            end
            default: begin
              // kCLR and any unassigned encoding clear the flags only.
              ci_d     = 1'b0;
              z_d      = 1'b0;
              neg_d    = 1'b0;
              retire_d = 1'b1;
            end
          endcase
        end
      end

      S_RD_WAIT, S_WR_WAIT: begin
        // mem_ready is checked first so a response on the abort edge still completes normally.
        if (mem_ready) begin
          state_d  = S_IDLE;
          retire_d = 1'b1;
          if (state_q == S_RD_WAIT) begin
            if (ldr_q) begin
              rf_wdata_d = mem_rdata;
              rf_we_d    = 1'b1;
            end else begin
              acc_d = mem_rdata;
              z_d   = (mem_rdata == '0);
              neg_d = mem_rdata[DW-1];
            end
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = S_IDLE;
          retire_d  = 1'b1;
          mem_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      tmo_cnt_q   <= 8'd0;
      ldr_q       <= 1'b0;
      acc_q       <= '0;
      ci_q        <= 1'b0;
      z_q         <= 1'b0;
      neg_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rf_we_q     <= 1'b0;
      rf_wdata_q  <= '0;
      retire_q    <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      ldr_q       <= ldr_d;
      acc_q       <= acc_d;
      ci_q        <= ci_d;
      z_q         <= z_d;
      neg_q       <= neg_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rf_we_q     <= rf_we_d;
      rf_wdata_q  <= rf_wdata_d;
      retire_q    <= retire_d;
      mem_err_q   <= mem_err_d;
    end
  end

`ifdef ACC_WB_PERF_CNT_EN
  logic [15:0] perf_retired_q, perf_retired_d;
  logic [15:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_retired_d = perf_retired_q;
    perf_stall_d   = perf_stall_q;
    if (retire_q && (perf_retired_q != 16'hFFFF)) perf_retired_d = perf_retired_q + 16'd1;
    if (ex_valid && !ex_ready && (perf_stall_q != 16'hFFFF)) perf_stall_d = perf_stall_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      perf_retired_q <= 16'd0;
      perf_stall_q   <= 16'd0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_acc_writeback.sv
// Bench for acc_writeback: directed instruction sequence, an architectural model
// checked every cycle, and hand-computed expectations at key points.
module tb_acc_writeback;
  import definitions::*;

  localparam int TMO = 15;

  logic       CLK = 1'b0;
  logic       reset_n = 1'b1;
  logic       ex_valid = 1'b0;
  logic       ex_ready;
  logic [3:0] op = 4'h0;
  logic [7:0] alu_acc = 8'h00;
  logic       alu_co = 1'b0, alu_z = 1'b0, alu_neg = 1'b0;
  logic [7:0] mem_addr_in = 8'h00;
  logic [7:0] acc_q;
  logic       ci_q, z_q, neg_q;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_ready = 1'b0;
  logic       rf_we;
  logic [7:0] rf_wdata;
  logic       retire, mem_err;

  acc_writeback dut (
    .CLK(CLK), .reset_n(reset_n), .ex_valid(ex_valid), .ex_ready(ex_ready), .op(op),
    .alu_acc(alu_acc), .alu_co(alu_co), .alu_z(alu_z), .alu_neg(alu_neg),
    .mem_addr_in(mem_addr_in), .acc_q(acc_q), .ci_q(ci_q), .z_q(z_q), .neg_q(neg_q),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .rf_we(rf_we), .rf_wdata(rf_wdata),
    .retire(retire), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  // Architectural model: what the stage must show after each edge.
  logic       m_busy = 0, m_write = 0, m_ldr = 0;
  int         m_waited = 0;
  logic [7:0] m_acc = 0, m_addr = 0, m_wdata = 0, m_rf_wdata = 0;
  logic       m_ci = 0, m_z = 0, m_neg = 0, m_rf_we = 0, m_retire = 0, m_err = 0;

  always @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_write = 0; m_ldr = 0; m_waited = 0;
      m_acc = 0; m_addr = 0; m_wdata = 0; m_rf_wdata = 0;
      m_ci = 0; m_z = 0; m_neg = 0; m_rf_we = 0; m_retire = 0; m_err = 0;
    end else begin
      m_retire = 0;
      m_rf_we  = 0;
      if (!m_busy) begin
        if (ex_valid) begin
          if (op == kADD || op == kSUB || op == kSHL) begin
            m_acc = alu_acc; m_ci = alu_co; m_z = alu_z; m_neg = alu_neg; m_retire = 1;
          end else if (op == kAND || op == kXOR || op == kSHR || op == kNOT || op == kLDI) begin
            m_acc = alu_acc; m_z = alu_z; m_neg = alu_neg; m_retire = 1;
          end else if (op == kJMP || op == kBRZ) begin
            m_z = alu_z; m_retire = 1;
          end else if (op == kBRN) begin
            m_retire = 1;
          end else if (op == kMLD || op == kLDR || op == kMST || op == kSTR) begin
            m_busy = 1; m_waited = 0; m_addr = mem_addr_in;
            m_write = (op == kMST || op == kSTR);
            m_ldr = (op == kLDR);
            if (op == kMST) m_wdata = m_acc;
            if (op == kSTR) begin m_wdata = alu_acc; m_z = alu_z; end
          end else begin
            m_ci = 0; m_z = 0; m_neg = 0; m_retire = 1;
          end
        end
      end else if (mem_ready) begin
        m_busy = 0; m_retire = 1;
        if (!m_write && m_ldr) begin
          m_rf_wdata = mem_rdata; m_rf_we = 1;
        end else if (!m_write) begin
          m_acc = mem_rdata; m_z = (mem_rdata == 8'h00); m_neg = mem_rdata[7];
        end
      end else begin
        m_waited++;
        if (m_waited == TMO) begin
          m_busy = 0; m_retire = 1; m_err = 1;
        end
      end
    end
  end

  int checks = 0, errors = 0;
  int retire_cnt = 0, rf_we_cnt = 0, stall_cnt = 0, req_cnt = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic co, input logic z,
                       input logic n, input logic [7:0] ad);
    int b = 0;
    while (!ex_ready && b < 100) begin tick(); b++; end
    if (!ex_ready) begin
      checks++; errors++;
      $display("FAIL issue_wait ex_ready stuck low, required 1");
    end
    op = o; alu_acc = a; alu_co = co; alu_z = z; alu_neg = n; mem_addr_in = ad;
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    op = 4'h0; alu_acc = 8'h00; alu_co = 0; alu_z = 0; alu_neg = 0; mem_addr_in = 8'h00;
  endtask

  // Called in the first wait cycle: mem_ready is raised in wait cycle n.
  task automatic mem_resp(input int n, input logic [7:0] rd);
    for (int i = 1; i < n; i++) tick();
    mem_ready = 1'b1; mem_rdata = rd;
    tick();
    mem_ready = 1'b0; mem_rdata = 8'h00;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  int base_ret, base_rf, base_stall, base_req, b;

  initial begin
    #1 reset_n = 1'b0;
    tick(); tick();
    chk("reset_acc", acc_q, 8'h00);
    chk("reset_ex_ready", 8'(ex_ready), 8'h01);
    chk("reset_mem_req", 8'(mem_req), 8'h00);
    chk("reset_mem_err", 8'(mem_err), 8'h00);
    reset_n = 1'b1;

    // Per-cycle comparison against the model, plus event counters.
    fork
      forever begin
        @(negedge CLK);
        chk("cyc_ex_ready", 8'(ex_ready), 8'(!m_busy));
        chk("cyc_acc", acc_q, m_acc);
        chk("cyc_ci", 8'(ci_q), 8'(m_ci));
        chk("cyc_z", 8'(z_q), 8'(m_z));
        chk("cyc_neg", 8'(neg_q), 8'(m_neg));
        chk("cyc_mem_req", 8'(mem_req), 8'(m_busy));
        chk("cyc_mem_we", 8'(mem_we), 8'(m_busy && m_write));
        chk("cyc_mem_addr", mem_addr, m_addr);
        chk("cyc_mem_wdata", mem_wdata, m_wdata);
        chk("cyc_rf_we", 8'(rf_we), 8'(m_rf_we));
        chk("cyc_rf_wdata", rf_wdata, m_rf_wdata);
        chk("cyc_retire", 8'(retire), 8'(m_retire));
        chk("cyc_mem_err", 8'(mem_err), 8'(m_err));
        if (retire) retire_cnt++;
        if (rf_we) rf_we_cnt++;
        if (!ex_ready) stall_cnt++;
        if (mem_req) req_cnt++;
      end
    join_none
    tick();

    // ADD chain
    base_ret = retire_cnt;
    issue(kADD, 8'hF0, 0, 0, 1, 8'h00);
    issue(kADD, 8'h10, 1, 0, 0, 8'h00);
    tick();
    chk("add_acc", acc_q, 8'h10);
    chk("add_ci", 8'(ci_q), 8'h01);
    chk("add_z", 8'(z_q), 8'h00);
    chk("add_retires", 8'(retire_cnt - base_ret), 8'h02);

    // Flag-only and logic ops
    issue(kCLR, 8'hAA, 1, 1, 1, 8'h00);
    tick();
    chk("clr_ci", 8'(ci_q), 8'h00);
    chk("clr_acc", acc_q, 8'h10);
    issue(kSUB, 8'h0F, 1, 0, 0, 8'h00);
    issue(kXOR, 8'h00, 0, 1, 0, 8'h00);
    issue(kBRN, 8'hFF, 0, 0, 1, 8'h00);
    tick();
    chk("xor_ci_held", 8'(ci_q), 8'h01);
    chk("xor_acc", acc_q, 8'h00);
    chk("brn_z_held", 8'(z_q), 8'h01);

    // Stray mem_ready while idle must do nothing
    mem_ready = 1'b1; mem_rdata = 8'h77;
    tick();
    mem_ready = 1'b0; mem_rdata = 8'h00;
    tick();
    chk("stray_ready_acc", acc_q, 8'h00);

    // Load
    base_stall = stall_cnt;
    issue(kMLD, 8'h00, 0, 0, 0, 8'h22);
    chk("mld_addr", mem_addr, 8'h22);
    mem_resp(3, 8'h80);
    chk("mld_stall", 8'(stall_cnt - base_stall), 8'h03);
    chk("mld_acc", acc_q, 8'h80);
    chk("mld_neg", 8'(neg_q), 8'h01);
    chk("mld_z", 8'(z_q), 8'h00);

    // Store
    issue(kLDI, 8'h5A, 0, 0, 0, 8'h00);
    issue(kMST, 8'h00, 0, 0, 0, 8'h07);
    chk("mst_we", 8'(mem_we), 8'h01);
    chk("mst_wdata", mem_wdata, 8'h5A);
    chk("mst_addr", mem_addr, 8'h07);
    mem_resp(2, 8'h00);
    chk("mst_acc", acc_q, 8'h5A);

    // Register load
    issue(kJMP, 8'h00, 0, 1, 0, 8'h00);
    base_rf = rf_we_cnt;
    issue(kLDR, 8'h00, 0, 0, 0, 8'h10);
    mem_resp(1, 8'h00);
    tick(); tick();
    chk("ldr_rf_we_pulses", 8'(rf_we_cnt - base_rf), 8'h01);
    chk("ldr_rf_wdata", rf_wdata, 8'h00);
    chk("ldr_z_held", 8'(z_q), 8'h01);
    chk("ldr_acc_held", acc_q, 8'h5A);

    // Timeout with no response
    base_req = req_cnt;
    base_ret = retire_cnt;
    issue(kMLD, 8'h00, 0, 0, 0, 8'h30);
    b = 0;
    while (mem_req && b < 100) begin tick(); b++; end
    if (mem_req) begin
      checks++; errors++;
      $display("FAIL tmo_exit mem_req still 1, required 0");
    end
    tick();
    chk("tmo_req_cycles", 8'(req_cnt - base_req), 8'(TMO));
    chk("tmo_err", 8'(mem_err), 8'h01);
    chk("tmo_acc", acc_q, 8'h5A);
    chk("tmo_retire", 8'(retire_cnt - base_ret), 8'h01);

    // Response on the last permitted wait cycle
    do_reset();
    base_req = req_cnt;
    issue(kMLD, 8'h00, 0, 0, 0, 8'h31);
    mem_resp(TMO, 8'h33);
    chk("tmo_edge_req_cycles", 8'(req_cnt - base_req), 8'(TMO));
    chk("tmo_edge_acc", acc_q, 8'h33);
    chk("tmo_edge_err", 8'(mem_err), 8'h00);

    // Reset in the middle of a write
    issue(kSTR, 8'h99, 0, 0, 0, 8'h44);
    tick(); tick();
    base_ret = retire_cnt;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_req", 8'(mem_req), 8'h00);
    chk("rst_mid_ready", 8'(ex_ready), 8'h01);
    chk("rst_mid_acc", acc_q, 8'h00);
    chk("rst_mid_wdata", mem_wdata, 8'h00);
    chk("rst_mid_addr", mem_addr, 8'h00);
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
    chk("rst_mid_no_retire", 8'(retire_cnt - base_ret), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
